// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential radix-2 Booth multiplier, one step per clock, hi/lo product outputs
// Optional build macro: MULT_UNSIGNED_EN adds the `uns` port and one extra Booth step (multu support).
module booth_mult #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
`ifdef MULT_UNSIGNED_EN
  input  logic         uns,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

`ifdef MULT_UNSIGNED_EN
  // One guard bit lets zero-extended operands go through the signed algorithm.
  localparam int WE = W + 1;
`else
  localparam int WE = W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WE-1:0]       r_m;
  logic [2*WE:0]       r_acc;
  logic [CNT_W-1:0]    r_count;
  logic [W-1:0]        r_hi;
  logic [W-1:0]        r_lo;

  logic [WE-1:0]       w_a_ext;
  logic [WE-1:0]       w_b_ext;
  logic [WE:0]         w_upper;
  logic [WE:0]         w_m_ext;
  logic [WE:0]         w_sum;
  logic [2*WE:0]       w_acc_step;
  logic                w_last;
  logic                w_capture;

`ifdef MULT_UNSIGNED_EN
  assign w_a_ext = {(~uns & a[W-1]), a};
  assign w_b_ext = {(~uns & b[W-1]), b};
`else
  assign w_a_ext = a;
  assign w_b_ext = b;
`endif

  // The add/sub runs one bit wider than the upper half so that subtracting the
  // most-negative multiplicand (e.g. 0x80000000 * 0x80000000) stays exact; that
  // extra bit becomes the replicated MSB of the arithmetic shift.
  assign w_upper    = {r_acc[2*WE], r_acc[2*WE:WE+1]};
  assign w_m_ext    = {r_m[WE-1], r_m};
  assign w_acc_step = {w_sum, r_acc[WE:1]};
  assign w_last     = (r_count == CNT_W'(WE - 1));
  assign w_capture  = start && (r_state != S_RUN);

  // Booth recoding of the two low accumulator bits: add, subtract or pass.
  always_comb begin
    w_sum = w_upper;
    case (r_acc[1:0])
      2'b01:   w_sum = w_upper + w_m_ext;
      2'b10:   w_sum = w_upper - w_m_ext;
      default: w_sum = w_upper;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and status outputs; start is only honoured outside RUN.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, Booth steps, and output registers that only
  // change on the step that completes the product.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_m     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_capture) begin
      r_m     <= w_a_ext;
      r_acc   <= {{WE{1'b0}}, w_b_ext, 1'b0};
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_step;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_acc_step[2*W:W+1];
        r_lo <= w_acc_step[W:1];
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - scoreboard testbench for booth_mult (directed vectors, optional MULT_UNSIGNED_EN)
module tb_booth_mult;

  localparam int W = 32;
`ifdef MULT_UNSIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULT_UNSIGNED_EN
  logic         uns;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last;

  always #5 Clk = ~Clk;

  booth_mult dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
`ifdef MULT_UNSIGNED_EN
    .uns   (uns),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every done pulse pops one expected product from the scoreboard.
  always @(negedge Clk) begin
    logic [2*W-1:0] e;
    if (busy === 1'b1 && done === 1'b1) check("busy_done_overlap", 64'd1, 64'd0);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e[63:32]));
        check("lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  // One multiply: busy for LAT cycles with hi/lo holding the previous result,
  // then a single done cycle. restart_at>0 pulses start mid-RUN.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2*W-1:0] e, input int restart_at);
    a = ia; b = ib; start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge Clk);
      check("busy_run", 64'(busy), 64'd1);
      check("hi_hold", 64'(hi), 64'(last[63:32]));
      check("lo_hold", 64'(lo), 64'(last[31:0]));
      if (i == restart_at) begin a = 32'd5; b = 32'd5; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    @(negedge Clk);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    last = e;
    tick();
    @(negedge Clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; a = '0; b = '0; last = '0;
`ifdef MULT_UNSIGNED_EN
    uns = 1'b0;
`endif
    tick(); tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    run_op(32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 0);
    run_op(32'h80000000, 32'h80000000, 64'h40000000_00000000, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 0);
    run_op(32'd100,      32'hFFFFFC18, 64'hFFFFFFFF_FFFE7960, 10);
    run_op(32'd0,        32'h80000000, 64'h00000000_00000000, 0);
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 0);
    run_op(32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 0);
    run_op(32'h12345678, 32'd0,        64'h00000000_00000000, 0);

    // Reset in the middle of a multiply: no done pulse may follow.
    a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    last = '0;
    for (int i = 0; i < LAT + 5; i++) tick();
    run_op(32'd6, 32'd7, 64'd42, 0);

    // start held high: back-to-back multiplies, busy low only in done cycles.
    a = 32'd2; b = 32'd3; start = 1'b1;
    repeat (3) exp_q.push_back(64'd6);
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i <= LAT; i++) begin
        @(negedge Clk);
        check("busy_stream", 64'(busy), 64'd1);
        tick();
      end
      @(negedge Clk);
      check("done_stream", 64'(done), 64'd1);
      check("busy_stream_done", 64'(busy), 64'd0);
      if (k == 2) start = 1'b0;
      tick();
    end
    last = 64'd6;

`ifdef MULT_UNSIGNED_EN
    uns = 1'b1;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
    run_op(32'h80000000, 32'h80000000, 64'h40000000_00000000, 0);
    run_op(32'h80000000, 32'd2,        64'h00000001_00000000, 0);
    uns = 1'b0;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 0);
    run_op(32'h80000000, 32'd2,        64'hFFFFFFFF_00000000, 0);
`endif

    for (int i = 0; i < 5; i++) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
